// File: rtl/mult_div_unit.sv
// Signed 32x32 multiply (radix-2 Booth) and signed 32/32 restoring divide.
// A start is captured in IDLE and acted on the next edge, so every operation sees the same one-edge setup.
module mult_div_unit (
  input  logic        clock,
  input  logic        reset,
  input  logic        mult_start,
  input  logic        div_start,
  input  logic [31:0] a_in,
  input  logic [31:0] b_in,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out,
  output logic        busy,
  output logic        done,
  output logic        div_zero
);

  typedef enum logic [1:0] {IDLE, MULT, DIV, DONE} state_t;

  state_t      state;
  logic        req_mult, req_div, req_zero;
  logic [31:0] a_q, b_q;
  logic [4:0]  cnt;
  logic [65:0] prod;
  logic [32:0] rem;
  logic [31:0] quo;
  logic [31:0] mag_b;
  logic        neg_q, neg_r;

  logic [32:0] m_ext, booth_sum;
  logic [65:0] prod_nxt;
  logic [32:0] rem_shift, rem_diff, rem_nxt;
  logic [31:0] quo_nxt;
  logic        pending;

  assign pending = req_mult | req_div | req_zero;

  // One Booth step: add/subtract multiplicand on {Q0, Q-1}, then arithmetic shift right.
  always_comb begin
    m_ext     = {a_q[31], a_q};
    booth_sum = prod[65:33];
    case (prod[1:0])
      2'b01:   booth_sum = prod[65:33] + m_ext;
      2'b10:   booth_sum = prod[65:33] - m_ext;
      default: booth_sum = prod[65:33];
    endcase
    prod_nxt = {booth_sum[32], booth_sum, prod[32:1]};
  end

  // One restoring-division step on magnitudes; borrow in bit 32 means restore.
  always_comb begin
    rem_shift = {rem[31:0], quo[31]};
    rem_diff  = rem_shift - {1'b0, mag_b};
    if (rem_diff[32]) begin
      rem_nxt = rem_shift;
      quo_nxt = {quo[30:0], 1'b0};
    end else begin
      rem_nxt = rem_diff;
      quo_nxt = {quo[30:0], 1'b1};
    end
  end

  function automatic logic [31:0] mag(input logic [31:0] v);
    return v[31] ? (32'd0 - v) : v;
  endfunction

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      req_mult <= 1'b0;
      req_div  <= 1'b0;
      req_zero <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      cnt      <= '0;
      prod     <= '0;
      rem      <= '0;
      quo      <= '0;
      mag_b    <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      hi_out   <= '0;
      lo_out   <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pending) begin
            req_mult <= 1'b0;
            req_div  <= 1'b0;
            req_zero <= 1'b0;
            busy     <= 1'b1;
            cnt      <= 5'd31;
            if (req_mult) begin
              prod  <= {33'd0, b_q, 1'b0};
              state <= MULT;
            end else if (req_div) begin
              quo   <= mag(a_q);
              mag_b <= mag(b_q);
              rem   <= '0;
              neg_q <= a_q[31] ^ b_q[31];
              neg_r <= a_q[31];
              state <= DIV;
            end else begin
              done     <= 1'b1;
              div_zero <= 1'b1;
              state    <= DONE;
            end
          end else if (mult_start || div_start) begin
            a_q      <= a_in;
            b_q      <= b_in;
            req_mult <= mult_start;
            req_div  <= !mult_start && (b_in != 32'd0);
            req_zero <= !mult_start && (b_in == 32'd0);
          end
        end
        MULT: begin
          prod <= prod_nxt;
          cnt  <= cnt - 5'd1;
          if (cnt == 5'd0) begin
            hi_out <= prod_nxt[64:33];
            lo_out <= prod_nxt[32:1];
            done   <= 1'b1;
            state  <= DONE;
          end
        end
        DIV: begin
          rem <= rem_nxt;
          quo <= quo_nxt;
          cnt <= cnt - 5'd1;
          if (cnt == 5'd0) begin
            lo_out <= neg_q ? (32'd0 - quo_nxt) : quo_nxt;
            hi_out <= neg_r ? (32'd0 - rem_nxt[31:0]) : rem_nxt[31:0];
            done   <= 1'b1;
            state  <= DONE;
          end
        end
        default: begin
          done     <= 1'b0;
          div_zero <= 1'b0;
          busy     <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: multiply, divide, divide-by-zero, reset abort,
// start priority and back-to-back operation, with hand-computed expected values.
module tb_mult_div_unit;

  logic        clock;
  logic        reset;
  logic        mult_start;
  logic        div_start;
  logic [31:0] a_in;
  logic [31:0] b_in;
  logic [31:0] hi_out;
  logic [31:0] lo_out;
  logic        busy;
  logic        done;
  logic        div_zero;

  int checks = 0;
  int fails  = 0;

  mult_div_unit dut (
    .clock      (clock),
    .reset      (reset),
    .mult_start (mult_start),
    .div_start  (div_start),
    .a_in       (a_in),
    .b_in       (b_in),
    .hi_out     (hi_out),
    .lo_out     (lo_out),
    .busy       (busy),
    .done       (done),
    .div_zero   (div_zero)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    tick;
    tick;
    reset = 1'b0;
    checks++;
    if (hi_out !== 32'd0 || lo_out !== 32'd0 || busy !== 1'b0 || done !== 1'b0 || div_zero !== 1'b0) begin
      fails++;
      $display("FAIL reset_state: got hi=%h lo=%h busy=%b done=%b dz=%b, expected all zero",
               hi_out, lo_out, busy, done, div_zero);
    end
  endtask

  // Runs one multiply (mult=1) or divide (mult=0) with a nonzero divisor, checking E1..E34.
  task automatic run_op(input string name, input logic mult, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eh, input logic [31:0] el);
    a_in = a;
    b_in = b;
    mult_start = mult;
    div_start  = !mult;
    tick;
    mult_start = 1'b0;
    div_start  = 1'b0;
    a_in = 32'hA5A5A5A5;
    b_in = 32'h0;
    for (int e = 1; e <= 32; e++) begin
      tick;
      checks++;
      if (busy !== 1'b1 || done !== 1'b0) begin
        fails++;
        $display("FAIL %s busy_done_E%0d: got busy=%b done=%b, expected busy=1 done=0", name, e, busy, done);
      end
    end
    tick;
    checks++;
    if (done !== 1'b1 || busy !== 1'b1 || div_zero !== 1'b0) begin
      fails++;
      $display("FAIL %s flags_E33: got done=%b busy=%b dz=%b, expected 1 1 0", name, done, busy, div_zero);
    end
    checks++;
    if (hi_out !== eh || lo_out !== el) begin
      fails++;
      $display("FAIL %s result: got hi=%h lo=%h, expected hi=%h lo=%h", name, hi_out, lo_out, eh, el);
    end
    tick;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL %s idle_E34: got done=%b busy=%b, expected 0 0", name, done, busy);
    end
  endtask

  task automatic test_mult;
    run_op("mult_7_x_m3", 1'b1, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB);
    run_op("mult_min_x_min", 1'b1, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000);
    run_op("mult_m5_x_m6", 1'b1, 32'hFFFFFFFB, 32'hFFFFFFFA, 32'h00000000, 32'd30);
    run_op("mult_big", 1'b1, 32'h10000, 32'h10000, 32'h00000001, 32'h00000000);
  endtask

  task automatic test_div;
    run_op("div_m7_by_2", 1'b0, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run_op("div_overflow", 1'b0, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);
    run_op("div_7_by_m2", 1'b0, 32'd7, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD);
    run_op("div_m7_by_m2", 1'b0, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000003);
    run_op("div_100_by_7", 1'b0, 32'd100, 32'd7, 32'd2, 32'd14);
  endtask

  task automatic test_div_zero;
    run_op("div_prior", 1'b0, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
    a_in = 32'd5;
    b_in = 32'd0;
    div_start = 1'b1;
    tick;
    div_start = 1'b0;
    tick;
    checks++;
    if (done !== 1'b1 || div_zero !== 1'b1 || busy !== 1'b1) begin
      fails++;
      $display("FAIL div_zero_E1: got done=%b dz=%b busy=%b, expected 1 1 1", done, div_zero, busy);
    end
    checks++;
    if (hi_out !== 32'hFFFFFFFF || lo_out !== 32'hFFFFFFFD) begin
      fails++;
      $display("FAIL div_zero_hold: got hi=%h lo=%h, expected hi=ffffffff lo=fffffffd", hi_out, lo_out);
    end
    tick;
    checks++;
    if (done !== 1'b0 || div_zero !== 1'b0 || busy !== 1'b0 || hi_out !== 32'hFFFFFFFF) begin
      fails++;
      $display("FAIL div_zero_E2: got done=%b dz=%b busy=%b hi=%h, expected 0 0 0 ffffffff",
               done, div_zero, busy, hi_out);
    end
  endtask

  task automatic test_reset_mid;
    int seen_done;
    seen_done = 0;
    a_in = 32'h12345678;
    b_in = 32'd9;
    mult_start = 1'b1;
    tick;
    mult_start = 1'b0;
    for (int e = 1; e <= 9; e++) tick;
    reset = 1'b1;
    tick;
    reset = 1'b0;
    checks++;
    if (busy !== 1'b0 || hi_out !== 32'd0 || lo_out !== 32'd0 || done !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid: got busy=%b hi=%h lo=%h done=%b, expected 0 0 0 0", busy, hi_out, lo_out, done);
    end
    for (int e = 0; e < 30; e++) begin
      tick;
      if (done === 1'b1 || busy === 1'b1) seen_done++;
    end
    checks++;
    if (seen_done != 0) begin
      fails++;
      $display("FAIL reset_mid_no_done: got %0d active cycles, expected 0", seen_done);
    end
    run_op("mult_3_x_4", 1'b1, 32'd3, 32'd4, 32'd0, 32'd12);
  endtask

  task automatic test_priority;
    int extra;
    extra = 0;
    a_in = 32'd6;
    b_in = 32'd7;
    mult_start = 1'b1;
    div_start  = 1'b1;
    tick;
    mult_start = 1'b0;
    div_start  = 1'b0;
    for (int e = 1; e <= 33; e++) begin
      if (e == 5 || e == 6) begin
        div_start = 1'b1;
        b_in = 32'd0;
      end else begin
        div_start = 1'b0;
      end
      tick;
    end
    div_start = 1'b0;
    checks++;
    if (done !== 1'b1 || hi_out !== 32'd0 || lo_out !== 32'd42) begin
      fails++;
      $display("FAIL priority_mult: got done=%b hi=%h lo=%h, expected 1 0 0000002a", done, hi_out, lo_out);
    end
    for (int e = 0; e < 40; e++) begin
      tick;
      if (done === 1'b1 || div_zero === 1'b1) extra++;
    end
    checks++;
    if (extra != 0) begin
      fails++;
      $display("FAIL priority_no_extra_done: got %0d extra pulses, expected 0", extra);
    end
  endtask

  task automatic test_back_to_back;
    run_op("b2b_mult", 1'b1, 32'd2, 32'd3, 32'd0, 32'd6);
    run_op("b2b_div", 1'b0, 32'd9, 32'd4, 32'd1, 32'd2);
    run_op("b2b_mult2", 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'd1);
  endtask

  initial begin
    reset = 1'b1;
    mult_start = 1'b0;
    div_start  = 1'b0;
    a_in = '0;
    b_in = '0;
    test_reset;
    test_mult;
    test_div;
    test_div_zero;
    test_reset_mid;
    test_priority;
    test_back_to_back;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
